// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types, mode decode and parameter checks for the I2S/TDM transmitter
package i2s_pkg;

    typedef enum logic [1:0] {
        I2S_PHILIPS = 2'd0,
        I2S_LJ      = 2'd1,
        I2S_TDM     = 2'd2
    } i2s_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ctr_state_e;

    // The reserved encoding falls back to Philips I2S.
    function automatic i2s_mode_e mode_decode(input logic [1:0] m);
        case (m)
            2'd1:    return I2S_LJ;
            2'd2:    return I2S_TDM;
            default: return I2S_PHILIPS;
        endcase
    endfunction

    function automatic logic lrclk_idle(input i2s_mode_e m);
        return (m == I2S_LJ);
    endfunction

    function automatic bit params_ok(input int sample_w, input int slot_w, input int channels);
        return (sample_w >= 8) && (sample_w <= 32) && (slot_w >= sample_w) && (slot_w <= 64)
            && (channels >= 2) && (channels <= 8) && ((channels % 2) == 0);
    endfunction

endpackage

// File: rtl/i2s_tdm_tx_if.sv
// rtl/i2s_tdm_tx_if.sv - frame-wide valid/ready input bus of the transmitter
interface i2s_tdm_tx_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16
);
    logic [CHANNELS*SAMPLE_W-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_frame_ctr.sv
// rtl/i2s_frame_ctr.sv - bit/slot counter, run/idle control and frame boundary strobes
module i2s_frame_ctr
    import i2s_pkg::*;
#(
    parameter int  SLOT_W   = 32,
    parameter int  CHANNELS = 2,
    localparam int FRAME_W  = CHANNELS * SLOT_W,
    localparam int CNT_W    = $clog2(FRAME_W),
    localparam int SLOT_IW  = $clog2(CHANNELS),
    localparam int BIT_IW   = $clog2(SLOT_W)
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    output logic [CNT_W-1:0]   p_nxt,
    output logic [SLOT_IW-1:0] slot_nxt,
    output logic [BIT_IW-1:0]  bit_nxt,
    output logic               run_nxt,
    output logic               load,
    output logic               frame_end,
    output logic               frame_start
);

    ctr_state_e         state_q, state_d;
    logic [CNT_W-1:0]   p_q;
    logic [SLOT_IW-1:0] slot_q;
    logic [BIT_IW-1:0]  bit_q;
    logic               last;

    assign last    = (p_q == CNT_W'(FRAME_W - 1));
    assign run_nxt = (state_d == ST_RUN);

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            slot_q      <= '0;
            bit_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_nxt;
            slot_q      <= slot_nxt;
            bit_q       <= bit_nxt;
            frame_start <= load;
        end
    end

    // Counters advance only mid-frame; every boundary and all of idle sit at p=0.
    always_comb begin
        state_d  = state_q;
        p_nxt    = '0;
        slot_nxt = '0;
        bit_nxt  = '0;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            default: if (last && !enable) state_d = ST_IDLE;
        endcase
        if (state_q == ST_RUN && !last) begin
            p_nxt = p_q + CNT_W'(1);
            if (bit_q == BIT_IW'(SLOT_W - 1)) begin
                slot_nxt = slot_q + SLOT_IW'(1);
            end else begin
                slot_nxt = slot_q;
                bit_nxt  = bit_q + BIT_IW'(1);
            end
        end
    end

    always_comb begin
        load      = enable && ((state_q == ST_IDLE) || last);
        frame_end = load || (state_q == ST_RUN && last && !enable);
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// rtl/i2s_tdm_tx.sv - I2S / left-justified / TDM transmitter and frame master, double-buffered
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int CHANNELS = 2
) (
    input  logic            sclk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      mode,
    i2s_tdm_tx_if.slave     src,
    output logic            lrclk,
    output logic            sdata,
    output logic            frame_start,
    output logic            underrun
);

    localparam int FRAME_W = CHANNELS * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int DATA_W  = CHANNELS * SAMPLE_W;
    localparam int IDX_W   = $clog2(DATA_W);
    localparam int SLOT_IW = $clog2(CHANNELS);
    localparam int BIT_IW  = $clog2(SLOT_W);

    if (!params_ok(SAMPLE_W, SLOT_W, CHANNELS)) begin : g_param_err
        $error("i2s_tdm_tx: illegal SAMPLE_W/SLOT_W/CHANNELS combination");
    end

    logic [CNT_W-1:0]   p_nxt;
    logic [SLOT_IW-1:0] slot_nxt;
    logic [BIT_IW-1:0]  bit_nxt;
    logic               run_nxt, load, frame_end;

    i2s_frame_ctr #(
        .SLOT_W   (SLOT_W),
        .CHANNELS (CHANNELS)
    ) u_ctr (
        .sclk        (sclk),
        .rst         (rst),
        .enable      (enable),
        .p_nxt       (p_nxt),
        .slot_nxt    (slot_nxt),
        .bit_nxt     (bit_nxt),
        .run_nxt     (run_nxt),
        .load        (load),
        .frame_end   (frame_end),
        .frame_start (frame_start)
    );

    logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic              hold_full_q, hold_full_d;
    logic              in_ready_q, xfer;
    i2s_mode_e         mode_r, mode_d;
    logic              u_q, u_d, sdata_q, sdata_d, lrclk_q, lrclk_d, underrun_q, underrun_d;
    logic [IDX_W-1:0]  idx;

    assign xfer         = src.in_valid && in_ready_q;
    assign src.in_ready = in_ready_q;
    assign sdata        = sdata_q;
    assign lrclk        = lrclk_q;
    assign underrun     = underrun_q;

    // A transfer on the load edge with holding empty bypasses straight into the shifter.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        underrun_d  = 1'b0;
        if (load) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (xfer) begin
                shift_d = src.in_data;
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (xfer) begin
            hold_d      = src.in_data;
            hold_full_d = 1'b1;
        end
        mode_d = frame_end ? mode_decode(mode) : mode_r;
    end

    // Raw bit for the coming cycle; u_q delays it by one bit for I2S and TDM.
    always_comb begin
        idx = '0;
        u_d = 1'b0;
        if (int'(bit_nxt) < SAMPLE_W) begin
            idx = IDX_W'(int'(slot_nxt) * SAMPLE_W + SAMPLE_W - 1 - int'(bit_nxt));
            u_d = shift_d[idx];
        end
        if (!run_nxt) begin
            sdata_d = 1'b0;
            lrclk_d = lrclk_idle(mode_d);
        end else begin
            sdata_d = (mode_d == I2S_LJ) ? u_d : u_q;
            case (mode_d)
                I2S_LJ:  lrclk_d = (int'(p_nxt) < FRAME_W / 2);
                I2S_TDM: lrclk_d = (p_nxt == '0);
                default: lrclk_d = (int'(p_nxt) >= FRAME_W / 2);
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            in_ready_q  <= 1'b0;
            mode_r      <= I2S_PHILIPS;
            u_q         <= 1'b0;
            sdata_q     <= 1'b0;
            lrclk_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            in_ready_q  <= !hold_full_d;
            mode_r      <= mode_d;
            u_q         <= run_nxt ? u_d : 1'b0;
            sdata_q     <= sdata_d;
            lrclk_q     <= lrclk_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised I2S/left-justified/TDM serial audio transmitter and frame master. It runs entirely on the bit clock and generates the frame sync itself. It accepts one full frame of CHANNELS samples per valid/ready handshake, double-buffers it, and serialises it MSB-first into left-aligned slots. It sits between the audio datapath (mixer/DSP output) and the codec serial pins, and is the multi-channel, multi-mode replacement for the 2-channel I2S transmitter.

Parameters:
SAMPLE_W, 16, bits per sample (8..32)
SLOT_W, 32, bits per slot, must be >= SAMPLE_W (SAMPLE_W..64)
CHANNELS, 2, slots per frame, even, 2..8
FRAME_W, CHANNELS*SLOT_W, derived localparam: bits per frame
CNT_W, $clog2(FRAME_W), derived localparam: bit counter width

Ports:
sclk  in  1  bit clock; all flops on rising edge; the codec pin is driven with inverted sclk
rst  in  1  asynchronous, active-low reset
enable  in  1  run request, sampled only at frame boundary or while idle
mode  in  2  0=I2S, 1=left-justified, 2=TDM/DSP-A, 3=reserved (treated as 0)
in_data  in  CHANNELS*SAMPLE_W  frame; channel k at bits [k*SAMPLE_W +: SAMPLE_W], two's complement
in_valid  in  1  in_data valid
in_ready  out  1  holding buffer empty, registered
lrclk  out  1  frame sync / word select, registered
sdata  out  1  serial data, registered
frame_start  out  1  one-cycle pulse in the cycle where p=0
underrun  out  1  one-cycle pulse when a frame load finds no data

Behaviour:
- Reset (rst=0, async): p=0, idle, holding empty, shift and hold registers 0, mode_r=0. Outputs: sdata=0, lrclk=0, in_ready=0, frame_start=0, underrun=0. in_ready rises on the first edge after release.
- Bit counter p runs 0..FRAME_W-1 and wraps. Slot s=p/SLOT_W, bit b=p%SLOT_W.
- Raw bit u(p): sample[s][SAMPLE_W-1-b] for b<SAMPLE_W, else 0. Padding is always 0.
- Frame boundary is the edge that ends p=FRAME_W-1, or the enabling edge when idle. At this edge:
  - mode_r is latched from mode.
  - The holding buffer moves to the shift register and holding becomes empty.
  - If holding is empty, zeros are loaded and underrun pulses during the following p=0 cycle.
- Handshake: transfer when in_valid & in_ready. in_ready = holding empty.
  - A transfer on the boundary edge while holding is empty bypasses directly into the shift register. There is no underrun and holding stays empty.
- sdata timing:
  - LJ: sdata during p is u(p).
  - I2S and TDM: sdata during p is u(p-1). At p=0 it is the last bit of the previous frame, or 0 after idle or reset.
- lrclk:
  - I2S: 0 for p<FRAME_W/2, 1 otherwise (left = low).
  - LJ: inverted, so left = high.
  - TDM: 1 only at p=0.
- Idle: entered at a boundary with enable=0. p is held at 0, sdata=0, lrclk at the mode idle level (I2S 0, LJ 1, TDM 0), and no frame_start. The holding buffer keeps its data and the handshake stays live. enable=1 while idle starts a frame with p=0 on the next edge.
- enable falling mid-frame: the current frame completes and the block then goes idle.
- mode changing mid-frame: takes effect at the next boundary only.
- Outputs are glitch-free (registered). The only combinational path is none; in_ready is registered.

Decomposition:
- Package i2s_pkg: mode enum (I2S_PHILIPS=0, I2S_LJ=1, I2S_TDM=2), lrclk idle-level function, parameter legality checks (SLOT_W>=SAMPLE_W, even CHANNELS).
- Sub-module i2s_frame_ctr owns p, slot/bit decode, frame_start, the boundary strobe and idle/run control. The top level owns holding/shift registers, the handshake, the delay flop and lrclk.

Test Plan:
- Default params, I2S, frames {L=16'hA5F0, R=16'h0F0F} back-to-back:
  - sdata at p=1..16 = A5F0 MSB-first, p=17..31 = 0.
  - p=33..48 = 0F0F.
  - lrclk toggles at p=0 and p=32; no underrun.
- LJ, same data: MSB at p=0 and p=32; lrclk=1 for p<32.
- TDM, CHANNELS=4, SLOT_W=16, samples 1,2,3,4 (16-bit): lrclk=1 only at p=0; sample k MSB at p=16k+1.
- Underrun:
  - withhold in_valid for one frame: underrun pulses at that frame's p=0 and all 64 bits are 0.
  - Next frame's data transmits normally.
- Bypass: in_valid asserted only on the boundary edge with holding empty → frame transmitted next with no underrun pulse.
- Async reset at p=20 mid-frame → all outputs 0 immediately. After release, in_ready=1 on the first edge, then a frame is transmitted with zero-fill first p=0 bit.
